// File: rtl/led_pkg.sv
// Shared types and constants for the status-code LED blinker.
// Holds the FSM state encoding and the special code values.
package led_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_OFF   = 4'd0;
  localparam logic [CODE_W-1:0] CODE_SOLID = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOLID,
    ST_ON,
    ST_OFF,
    ST_GAP
  } state_e;

endpackage

// File: rtl/led_phase_timer.sv
// Loadable down-counter timing one blink phase.
// Holds at zero until the next load.
module led_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/led_blink_code.sv
// Status-code LED: blinks code N as N pulses followed by a gap.
// Codes arriving mid-sequence wait in a one-entry pending slot.
module led_blink_code
  import led_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int GAP_UNITS   = 4
) (
  input  logic              sysclk2,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              led,
  output logic              busy
);

  localparam int GAP_CYC = GAP_UNITS * TICK_CYCLES;
  localparam int TW      = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  localparam logic [TW-1:0] UNIT_LD = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] pulses_q, pulses_d;
  logic [CODE_W-1:0] act_q, act_d;
  logic [CODE_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              led_q, led_d;

  logic              hs;
  logic              start;
  logic [CODE_W-1:0] start_code;
  logic              tmr_ld;
  logic [TW-1:0]     tmr_ld_val;
  logic [TW-1:0]     tmr_val;
  logic              tmr_zero;

  led_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (sysclk2),
    .rst_i      (rst),
    .load_i     (tmr_ld),
    .load_val_i (tmr_ld_val),
    .value_o    (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign code_ready = ~pend_vld_q;
  assign hs         = code_valid & code_ready;

  always_comb begin
    state_d    = state_q;
    pulses_d   = pulses_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    start      = 1'b0;
    start_code = act_q;
    tmr_ld     = 1'b0;
    tmr_ld_val = UNIT_LD;

    unique case (state_q)
      ST_IDLE, ST_SOLID: begin
        if (hs) begin
          start      = 1'b1;
          start_code = code;
        end
      end
      ST_ON: begin
        if (hs) begin
          pend_vld_d = 1'b1;
          pend_d     = code;
        end
        if (tmr_zero) begin
          pulses_d = pulses_q - 4'd1;
          tmr_ld   = 1'b1;
          if (pulses_q == 4'd1) begin
            state_d    = ST_GAP;
            tmr_ld_val = GAP_LD;
          end else begin
            state_d = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        if (hs) begin
          pend_vld_d = 1'b1;
          pend_d     = code;
        end
        if (tmr_zero) begin
          state_d = ST_ON;
          tmr_ld  = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          // Sequence boundary: pending wins, then a bypass handshake,
          // otherwise replay the active code.
          start = 1'b1;
          if (pend_vld_q) begin
            start_code = pend_q;
            pend_vld_d = 1'b0;
          end else if (hs) begin
            start_code = code;
          end
        end else if (hs) begin
          pend_vld_d = 1'b1;
          pend_d     = code;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      act_d = start_code;
      unique case (1'b1)
        (start_code == CODE_OFF):   state_d = ST_IDLE;
        (start_code == CODE_SOLID): state_d = ST_SOLID;
        default: begin
          state_d    = ST_ON;
          pulses_d   = start_code;
          tmr_ld     = 1'b1;
          tmr_ld_val = UNIT_LD;
        end
      endcase
    end

    led_d = (state_d == ST_SOLID) || (state_d == ST_ON);
  end

  always_ff @(posedge sysclk2 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pulses_q   <= '0;
      act_q      <= CODE_OFF;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pulses_q   <= pulses_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      led_q      <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == ST_ON) || (state_q == ST_OFF) ||
                (state_q == ST_GAP);

  logic unused_ok;
  assign unused_ok = ^tmr_val;

endmodule

// File: tb/tb_led_blink_code.sv
// Directed bench for led_blink_code with TICK_CYCLES=4, GAP_UNITS=4.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_led_blink_code;

  logic       sysclk2;
  logic       rst;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       led;
  logic       busy;

  int errors;
  int checks;
  logic [63:0] vec;
  logic        ball;
  logic        acc;

  led_blink_code #(
    .TICK_CYCLES (4),
    .GAP_UNITS   (4)
  ) dut (
    .sysclk2    (sysclk2),
    .rst        (rst),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .led        (led),
    .busy       (busy)
  );

  initial sysclk2 = 1'b0;
  always #5 sysclk2 = ~sysclk2;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk2);
    rst        = 1'b1;
    code_valid = 1'b0;
    @(negedge sysclk2);
    rst = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    code       = 4'd0;
    code_valid = 1'b0;

    // reset state
    repeat (2) @(negedge sysclk2);
    chk("rst_led", led, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", code_ready, 1'b1);
    rst = 1'b0;

    // code 3 from IDLE
    code       = 4'd3;
    code_valid = 1'b1;
    vec        = '0;
    ball       = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      @(negedge sysclk2);
      if (i == 1) code_valid = 1'b0;
      vec  = {vec[62:0], led};
      ball = ball & busy;
    end
    chk("seq3_pattern", vec, 64'hF0F0F0000);
    chk("seq3_busy", ball, 1'b1);
    @(negedge sysclk2);
    chk("seq3_repeat", led, 1'b1);

    // SOLID then IDLE
    do_reset();
    code       = 4'd15;
    code_valid = 1'b1;
    @(negedge sysclk2);
    code_valid = 1'b0;
    chk("solid_led", led, 1'b1);
    chk("solid_busy", busy, 1'b0);
    @(negedge sysclk2);
    chk("solid_hold", led, 1'b1);
    code       = 4'd0;
    code_valid = 1'b1;
    @(negedge sysclk2);
    code_valid = 1'b0;
    chk("off_led", led, 1'b0);
    chk("off_busy", busy, 1'b0);

    // code 2 running, 5 pended mid-ON, 7 ignored while full
    do_reset();
    code       = 4'd2;
    code_valid = 1'b1;
    vec        = '0;
    ball       = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge sysclk2);
      vec  = {vec[62:0], led};
      ball = ball & busy;
      if (i == 1) code_valid = 1'b0;
      if (i == 2) begin
        code       = 4'd5;
        code_valid = 1'b1;
      end
      if (i == 3) begin
        chk("pend_ready_low", code_ready, 1'b0);
        code = 4'd7;
      end
      if (i == 10) begin
        chk("full_ignore_ready", code_ready, 1'b0);
        code_valid = 1'b0;
      end
      if (i == 28) begin
        chk("seq2_pattern", vec, 64'hF0F0000);
        vec = '0;
      end
      if (i == 29) chk("pend_ready_back", code_ready, 1'b1);
    end
    chk("seq5_pattern", vec, 64'hF0F0F0F0F0000);
    chk("seq2_5_busy", ball, 1'b1);

    // reset mid-OFF with a pending code
    do_reset();
    code       = 4'd2;
    code_valid = 1'b1;
    @(negedge sysclk2);
    code_valid = 1'b0;
    @(negedge sysclk2);
    code       = 4'd5;
    code_valid = 1'b1;
    @(negedge sysclk2);
    code_valid = 1'b0;
    chk("mid_pend_full", code_ready, 1'b0);
    repeat (3) @(negedge sysclk2);
    chk("mid_off_led", led, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_led", led, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", code_ready, 1'b1);
    @(negedge sysclk2);
    rst = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk2);
      acc = acc | led | busy;
    end
    chk("idle_after_rst", acc, 1'b0);

    // first-edge handshake, then code 1 on the final GAP cycle
    @(negedge sysclk2);
    rst = 1'b1;
    @(negedge sysclk2);
    rst        = 1'b0;
    code       = 4'd2;
    code_valid = 1'b1;
    vec        = '0;
    for (int i = 1; i <= 49; i++) begin
      @(negedge sysclk2);
      vec = {vec[62:0], led};
      if (i == 1) begin
        chk("first_edge_hs", led, 1'b1);
        code_valid = 1'b0;
      end
      if (i == 28) begin
        vec = '0;
        chk("gap_end_ready", code_ready, 1'b1);
        code       = 4'd1;
        code_valid = 1'b1;
      end
      if (i == 29) begin
        code_valid = 1'b0;
        chk("bypass_ready", code_ready, 1'b1);
      end
    end
    chk("seq1_bypass", vec, 64'h1E0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_blink_code.md
LED_BLINK_CODE -- requirements
Module: led_blink_code

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 25_000_000, sysclk2 cycles per blink unit (250 ms at 100 MHz).
REQ-002 SHALL have parameter GAP_UNITS, default 4, length of the inter-sequence gap in blink units.
REQ-003 SHALL have port sysclk2  input  1  single clock, 100 MHz board clock after differential input buffer.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port code  input  4  requested status code.
REQ-006 SHALL have port code_valid  input  1  code is presented this cycle.
REQ-007 SHALL have port code_ready  output  1  block accepts code this cycle.
REQ-008 SHALL have port led  output  1  registered LED drive, 1 = lit, feeds the QSFP28 activity LED pin.
REQ-009 SHALL have port busy  output  1  high while a blink sequence (ON/OFF/GAP) is running.

Function
REQ-010 SHALL accept a code on any cycle where code_valid and code_ready are both high (handshake).
REQ-011 SHALL implement states IDLE (led 0), SOLID (led 1), ON (led 1), OFF (led 0), GAP (led 0).
REQ-012 Code 0 SHALL select IDLE, code 15 SHALL select SOLID, codes 1..14 SHALL select blink sequence N.
REQ-013 Blink sequence N SHALL be: ON 1 unit, OFF 1 unit, repeated N-1 times, then ON 1 unit, then GAP GAP_UNITS units, repeating indefinitely.
REQ-014 One unit SHALL be exactly TICK_CYCLES cycles; GAP SHALL be exactly GAP_UNITS*TICK_CYCLES cycles; sequence period = (2N-1+GAP_UNITS)*TICK_CYCLES.
REQ-015 Phase timer SHALL load the phase duration minus 1 on phase entry and count down to 0; phase transition occurs on the cycle the count is 0.
REQ-016 In IDLE or SOLID, an accepted code SHALL be applied at the handshake edge; led reflects the new state on the following cycle (1-cycle latency).
REQ-017 In ON/OFF/GAP, an accepted code SHALL be stored in a one-entry pending register and applied only at GAP end (sequence boundary).
REQ-018 code_ready SHALL be 1 when pending is empty, 0 when pending is full; a code_valid while code_ready is 0 SHALL be ignored, no overwrite.
REQ-019 Handshake on the same cycle as GAP end with pending empty SHALL apply the new code directly at that edge (bypass).
REQ-020 At GAP end with no pending code, the same sequence SHALL restart at ON.
REQ-021 Pulse counter SHALL be 4 bits, loaded with N on sequence start, decremented on each ON exit; GAP entered when it reaches 1 at ON exit.
REQ-022 busy SHALL be 1 exactly when state is ON, OFF or GAP.
REQ-023 Re-submitting the currently active code SHALL be handled like any other code (sequence restarts at boundary, no glitch).

Reset
REQ-024 rst high SHALL immediately force state IDLE, led 0, busy 0, pending empty, code_ready 1, timer and pulse counter 0.
REQ-025 Reset mid-sequence SHALL abort the sequence and discard any pending code; after release the block waits in IDLE.
REQ-026 First handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Shared package led_pkg SHALL hold the state enumeration and constants CODE_OFF = 0, CODE_SOLID = 15, CODE_W = 4.
REQ-028 The phase down-counter SHALL be a sub-module led_phase_timer (load, value, zero flag), width $clog2(GAP_UNITS*TICK_CYCLES).
REQ-029 Total RTL SHALL be one top module plus led_phase_timer and the package; no vendor primitives.

Verification (TICK_CYCLES=4, GAP_UNITS=4)
REQ-030 Code 3 from IDLE -> led H4 L4 H4 L4 H4 L16, period 36 cycles, repeats; busy 1 throughout.
REQ-031 Code 15 then code 0 -> led 1 one cycle after first handshake, led 0 one cycle after second; busy stays 0.
REQ-032 Code 2 running, code 5 sent mid-ON -> code_ready drops, code 2 sequence completes incl. GAP, then 5 pulses start; code_ready returns 1.
REQ-033 Pending full, further code_valid with code 7 -> ignored, code_ready stays 0, pending code applied unchanged.
REQ-034 rst asserted mid-OFF with pending code -> led 0, busy 0, code_ready 1 asynchronously; after release led stays 0 until a new code.
REQ-035 Handshake on GAP final cycle with code 1 -> next cycle ON, single 4-cycle pulse then 16-cycle gap.
